// File: rtl/sprite_reg_writer.sv
// Double-buffered sprite register store: host port edits the shadow bank, vblank copies it to the active bank.
// Host read and render fetch: 1-cycle latency; host writes are dropped while host_ready is low (CLEAR).
module sprite_reg_writer #(
  parameter int NUM_SPRITES   = 32,
  parameter int SPRITE_BITS   = 5,
  parameter int NUM_REGS      = 7,
  parameter int REG_ADDR_BITS = 3,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SPRITE_BITS+REG_ADDR_BITS-1:0] host_addr,
  input  logic                                 host_wr,
  input  logic                                 host_rd,
  input  logic [DATA_WIDTH-1:0]                host_data_in,
  output logic [DATA_WIDTH-1:0]                host_data_out,
  output logic                                 host_ready,
  input  logic                                 vblank_start,
  input  logic [SPRITE_BITS-1:0]               render_sprite,
  input  logic                                 render_req,
  output logic [NUM_REGS*DATA_WIDTH-1:0]       reg_values,
  output logic                                 render_valid,
  output logic                                 busy,
  output logic                                 copy_overrun
);

  typedef enum logic [1:0] {CLEAR, IDLE, COPY} state_t;

  localparam logic [SPRITE_BITS-1:0]   LAST_SPRITE = SPRITE_BITS'(NUM_SPRITES - 1);
  localparam logic [REG_ADDR_BITS:0]   REG_LIMIT   = (REG_ADDR_BITS + 1)'(NUM_REGS);

  state_t                   state, state_nxt;
  logic [SPRITE_BITS-1:0]   counter, counter_nxt;

  logic [DATA_WIDTH-1:0]    shadow [NUM_SPRITES][NUM_REGS];
  logic [DATA_WIDTH-1:0]    active [NUM_SPRITES][NUM_REGS];

  logic [SPRITE_BITS-1:0]   host_sprite;
  logic [REG_ADDR_BITS-1:0] host_reg;
  logic                     reg_ok;
  logic [NUM_REGS*DATA_WIDTH-1:0] fetch_vec;

  assign host_sprite = host_addr[SPRITE_BITS+REG_ADDR_BITS-1 -: SPRITE_BITS];
  assign host_reg    = host_addr[REG_ADDR_BITS-1:0];
  assign reg_ok      = ({1'b0, host_reg} < REG_LIMIT);

  assign busy       = (state != IDLE);
  assign host_ready = (state != CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    case (state)
      CLEAR: begin
        counter_nxt = counter + 1'b1;
        if (counter == LAST_SPRITE) state_nxt = IDLE;
      end
      IDLE: begin
        if (vblank_start) begin
          state_nxt   = COPY;
          counter_nxt = '0;
        end
      end
      COPY: begin
        counter_nxt = counter + 1'b1;
        if (counter == LAST_SPRITE) state_nxt = IDLE;
      end
      default: begin
        state_nxt   = CLEAR;
        counter_nxt = '0;
      end
    endcase
  end

  // Copy reads the pre-edge shadow, so a same-cycle host write to that sprite only lands in shadow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          shadow[counter][r] <= '0;
          active[counter][r] <= '0;
        end
      end else begin
        if (state == COPY) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            active[counter][r] <= shadow[counter][r];
          end
        end
        if (host_wr && reg_ok) shadow[host_sprite][host_reg] <= host_data_in;
      end
    end
  end

  always_comb begin
    fetch_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      fetch_vec[i*DATA_WIDTH +: DATA_WIDTH] = active[render_sprite][i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_data_out <= '0;
      reg_values    <= '0;
      render_valid  <= 1'b0;
      copy_overrun  <= 1'b0;
    end else begin
      if (host_rd) host_data_out <= reg_ok ? shadow[host_sprite][host_reg] : '0;
      if (render_req) reg_values <= fetch_vec;
      render_valid <= render_req;
      copy_overrun <= (state == COPY) && vblank_start;
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Bench for sprite_reg_writer: directed scenarios plus random traffic against a bank-level model.
module tb_sprite_reg_writer;
  localparam int NS = 32;
  localparam int NR = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   host_addr = '0;
  logic         host_wr = 1'b0;
  logic         host_rd = 1'b0;
  logic [15:0]  host_data_in = '0;
  logic [15:0]  host_data_out;
  logic         host_ready;
  logic         vblank_start = 1'b0;
  logic [4:0]   render_sprite = '0;
  logic         render_req = 1'b0;
  logic [111:0] reg_values;
  logic         render_valid;
  logic         busy;
  logic         copy_overrun;

  sprite_reg_writer dut (
    .clk(clk), .reset(reset), .host_addr(host_addr), .host_wr(host_wr), .host_rd(host_rd),
    .host_data_in(host_data_in), .host_data_out(host_data_out), .host_ready(host_ready),
    .vblank_start(vblank_start), .render_sprite(render_sprite), .render_req(render_req),
    .reg_values(reg_values), .render_valid(render_valid), .busy(busy), .copy_overrun(copy_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: banks as arrays, clear as a countdown, copy as a sprite position (-1 = not copying).
  logic [15:0]  sh [NS][NR];
  logic [15:0]  ac [NS][NR];
  int           clr_left = NS;
  int           cp = -1;
  logic [15:0]  e_hdo = '0;
  logic [111:0] e_rv = '0;
  logic         e_rval = 1'b0;
  logic         e_ovr = 1'b0;
  bit           started = 1'b0;

  function automatic logic [111:0] pack(input int s);
    logic [111:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*16 +: 16] = ac[s][i];
    return v;
  endfunction

  initial begin : model
    int s_, r_;
    forever begin
      @(posedge clk);
      if (reset) begin
        clr_left = NS; cp = -1;
        e_hdo = '0; e_rv = '0; e_rval = 1'b0; e_ovr = 1'b0;
        for (int s = 0; s < NS; s++)
          for (int r = 0; r < NR; r++) begin
            sh[s][r] = '0;
            ac[s][r] = '0;
          end
      end else begin
        s_ = int'(host_addr[7:3]);
        r_ = int'(host_addr[2:0]);
        e_ovr  = (cp >= 0) && vblank_start;
        e_rval = render_req;
        if (render_req) e_rv = pack(int'(render_sprite));
        if (host_rd) e_hdo = (r_ < NR) ? sh[s_][r_] : 16'h0;
        if (clr_left > 0) begin
          clr_left--;
        end else begin
          if (cp >= 0) begin
            for (int r = 0; r < NR; r++) ac[cp][r] = sh[cp][r];
            cp++;
            if (cp == NS) cp = -1;
          end else if (vblank_start) begin
            cp = 0;
          end
          if (host_wr && r_ < NR) sh[s_][r_] = host_data_in;
        end
      end
      started = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        chk("host_data_out", host_data_out, e_hdo);
        chk("reg_values", reg_values, e_rv);
        chk("render_valid", render_valid, e_rval);
        chk("copy_overrun", copy_overrun, e_ovr);
        chk("busy", busy, (clr_left > 0) || (cp >= 0));
        chk("host_ready", host_ready, clr_left == 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int s, input int r, input logic [15:0] d);
    host_addr = {s[4:0], r[2:0]};
    host_data_in = d;
    host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic rd(input int s, input int r, output logic [15:0] d);
    host_addr = {s[4:0], r[2:0]};
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    d = host_data_out;
  endtask

  task automatic fetch(input int s, output logic [111:0] v);
    render_sprite = s[4:0];
    render_req = 1'b1;
    tick();
    render_req = 1'b0;
    v = reg_values;
  endtask

  task automatic vblank();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!host_ready && n < 200);
  endtask

  initial begin : stim
    logic [15:0]  d;
    logic [111:0] v;
    logic [111:0] exp31;
    int           n;
    int           bc;

    repeat (3) tick();
    chk("reset_busy", busy, 1'b1);
    chk("reset_ready", host_ready, 1'b0);
    chk("reset_hdo", host_data_out, 16'h0);
    chk("reset_rv", reg_values, 112'h0);
    chk("reset_rvalid", render_valid, 1'b0);
    chk("reset_ovr", copy_overrun, 1'b0);
    reset = 1'b0;
    wait_ready(n);
    chk("clear_len", n, 32);
    for (int s = 0; s < NS; s++) begin
      fetch(s, v);
      chk("fetch_zero", v, 112'h0);
      chk("fetch_valid", render_valid, 1'b1);
    end

    wr(3, 0, 16'h8001);
    rd(3, 0, d);
    chk("rd_s3_ctrl0", d, 16'h8001);
    fetch(3, v);
    chk("pre_copy_s3", v[15:0], 16'h0);
    vblank();
    repeat (33) tick();
    fetch(3, v);
    chk("post_copy_s3", v[15:0], 16'h8001);

    for (int r = 0; r < NR; r++) wr(31, r, 16'((r + 1) * 16'h1111));
    exp31 = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    vblank();
    repeat (33) tick();
    fetch(31, v);
    chk("s31_all_regs", v, exp31);

    wr(10, 1, 16'h1234);
    vblank();
    repeat (33) tick();
    vblank();
    repeat (10) tick();
    wr(10, 1, 16'h00F0);
    repeat (25) tick();
    fetch(10, v);
    chk("copy_race_old", v[31:16], 16'h1234);
    rd(10, 1, d);
    chk("copy_race_shadow", d, 16'h00F0);
    vblank();
    repeat (33) tick();
    fetch(10, v);
    chk("copy_race_new", v[31:16], 16'h00F0);

    vblank();
    bc = busy ? 1 : 0;
    repeat (5) begin
      tick();
      bc += busy ? 1 : 0;
    end
    vblank();
    bc += busy ? 1 : 0;
    chk("overrun_pulse", copy_overrun, 1'b1);
    tick();
    bc += busy ? 1 : 0;
    chk("overrun_clear", copy_overrun, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      bc += busy ? 1 : 0;
    end
    chk("copy_len", bc, 32);
    wr(5, 7, 16'hBEEF);
    rd(5, 7, d);
    chk("reg7_read", d, 16'h0);

    for (int k = 0; k < 40; k++) wr($urandom_range(0, 31), $urandom_range(0, 6), 16'($urandom) | 16'h1);
    vblank();
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    chk("clear_len_again", n, 32);
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < NR; r++) begin
        rd(s, r, d);
        chk("post_reset_rd", d, 16'h0);
      end
    for (int s = 0; s < NS; s++) begin
      fetch(s, v);
      chk("post_reset_fetch", v, 112'h0);
    end

    repeat (3000) begin
      host_addr     = 8'($urandom);
      host_wr       = ($urandom_range(0, 2) == 0);
      host_rd       = ($urandom_range(0, 1) == 1);
      host_data_in  = 16'($urandom);
      render_sprite = 5'($urandom);
      render_req    = ($urandom_range(0, 1) == 1);
      vblank_start  = ($urandom_range(0, 39) == 0);
      tick();
    end
    host_wr = 1'b0; host_rd = 1'b0; render_req = 1'b0; vblank_start = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
